// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU data-memory request/response bundle
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  length;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, length, wdata,
        input  rdata, ready, err, busy
    );

    modport slave (
        input  req, we, addr, length, wdata,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated word memory answering CPU loads/stores
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic             we_q;
    logic [2:0]       len_q;
    logic [1:0]       lane_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_r;
    logic             ready_r;
    logic             err_r;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             req_err;
    logic             commit;
    logic [31:0]      cur_word;
    logic [31:0]      load_word;
    logic [31:0]      store_word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    always_comb begin
        req_err = 1'b0;
        case (bus.length)
            3'b000:         req_err = (bus.addr[1:0] != 2'b00);
            3'b001, 3'b010: req_err = bus.addr[0];
            3'b011, 3'b100: req_err = 1'b0;
            default:        req_err = 1'b1;
        endcase
        if ({2'b00, bus.addr[31:2]} >= 32'(DEPTH_WORDS)) begin
            req_err = 1'b1;
        end
    end

    assign commit = (state == ST_WAIT) && (cnt == WAIT_LAST);

    // Lane selection and merge work on the latched request only.
    always_comb begin
        cur_word = mem[idx_q];
        half_sel = lane_q[1] ? cur_word[31:16] : cur_word[15:0];
        case (lane_q)
            2'd0:    byte_sel = cur_word[7:0];
            2'd1:    byte_sel = cur_word[15:8];
            2'd2:    byte_sel = cur_word[23:16];
            default: byte_sel = cur_word[31:24];
        endcase

        case (len_q)
            3'b000:  load_word = cur_word;
            3'b001:  load_word = {16'h0000, half_sel};
            3'b010:  load_word = {{16{half_sel[15]}}, half_sel};
            3'b011:  load_word = {24'h000000, byte_sel};
            3'b100:  load_word = {{24{byte_sel[7]}}, byte_sel};
            default: load_word = 32'h0;
        endcase

        store_word = cur_word;
        case (len_q)
            3'b000: store_word = wdata_q;
            3'b001, 3'b010: begin
                if (lane_q[1]) store_word[31:16] = wdata_q[15:0];
                else           store_word[15:0]  = wdata_q[15:0];
            end
            3'b011, 3'b100: begin
                case (lane_q)
                    2'd0:    store_word[7:0]   = wdata_q[7:0];
                    2'd1:    store_word[15:8]  = wdata_q[7:0];
                    2'd2:    store_word[23:16] = wdata_q[7:0];
                    default: store_word[31:24] = wdata_q[7:0];
                endcase
            end
            default: store_word = cur_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            len_q   <= 3'd0;
            lane_q  <= 2'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            rdata_r <= 32'h0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0;
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        len_q   <= bus.length;
                        lane_q  <= bus.addr[1:0];
                        idx_q   <= bus.addr[IDX_W+1:2];
                        wdata_q <= bus.wdata;
                        cnt     <= 4'd0;
                        // Rejected requests skip the wait states entirely.
                        if (req_err) begin
                            state   <= ST_RESP;
                            ready_r <= 1'b1;
                            err_r   <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (commit) begin
                        state   <= ST_RESP;
                        ready_r <= 1'b1;
                        rdata_r <= we_q ? 32'h0 : load_word;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (commit && we_q && !rst) begin
            mem[idx_q] <= store_word;
        end
    end

    assign bus.rdata = rdata_r;
    assign bus.ready = ready_r;
    assign bus.err   = err_r;
    assign bus.busy  = (state != ST_IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;
    localparam int W2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dmem_responder_if b2 ();
    dmem_responder_if b0 ();

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(W2)) u_dut (.clk(clk), .rst(rst), .bus(b2));
    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0))  u_dut0 (.clk(clk), .rst(rst), .bus(b0));

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [21];
    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  mb [256];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    // Byte-addressed little-endian reference of the whole memory.
    function automatic void model_access(input logic w, input logic [31:0] a, input logic [2:0] l,
                                         input logic [31:0] d, output logic [31:0] r,
                                         output logic e, output int lat);
        int   size;
        logic sgn;
        sgn = (l == 3'd2) || (l == 3'd4);
        case (l)
            3'd0:       size = 4;
            3'd1, 3'd2: size = 2;
            3'd3, 3'd4: size = 1;
            default:    size = 0;
        endcase
        if (size == 0) e = 1'b1;
        else           e = ((a % 32'(size)) != 0) || (a >= 32'd256);
        r   = 32'h0;
        lat = e ? 1 : W2 + 2;
        if (!e) begin
            if (w) begin
                for (int i = 0; i < size; i++) mb[a + 32'(i)] = d[8*i +: 8];
            end else begin
                for (int i = 0; i < size; i++) r = r | (32'(mb[a + 32'(i)]) << (8*i));
                if (sgn && r[8*size-1]) r = r | (~32'h0 << (8*size));
            end
        end
    endfunction

    task automatic do_access(input logic w, input logic [31:0] a, input logic [2:0] l,
                             input logic [31:0] d, output logic [31:0] r, output logic e,
                             output int lat);
        @(negedge clk);
        b2.req = 1'b1; b2.we = w; b2.addr = a; b2.length = l; b2.wdata = d;
        @(posedge clk);
        lat = -1; r = 32'h0; e = 1'b0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (b2.ready) begin
                lat = n; r = b2.rdata; e = b2.err;
                b2.req = 1'b0;
            end else begin
                b2.req    = 1'($urandom);
                b2.we     = 1'($urandom);
                b2.addr   = $urandom;
                b2.length = 3'($urandom);
                b2.wdata  = $urandom;
            end
        end
        b2.req = 1'b0;
    endtask

    task automatic run_checked(input string name, input logic w, input logic [31:0] a,
                               input logic [2:0] l, input logic [31:0] d);
        logic [31:0] er, gr;
        logic        ee, ge;
        int          el, gl;
        model_access(w, a, l, d, er, ee, el);
        do_access(w, a, l, d, gr, ge, gl);
        check({name, " rdata"}, gr, er);
        check({name, " err"}, 32'(ge), 32'(ee));
        check({name, " latency"}, 32'(gl), 32'(el));
    endtask

    initial begin
        logic [31:0] r, dr;
        logic        e, de;
        int          lat, dl;

        vecs[0]  = '{1'b1, 32'h10, 3'd0, 32'hDEADBEEF, 32'h0,        1'b0, 4};
        vecs[1]  = '{1'b0, 32'h10, 3'd0, 32'h0,        32'hDEADBEEF, 1'b0, 4};
        vecs[2]  = '{1'b1, 32'h11, 3'd3, 32'h00000080, 32'h0,        1'b0, 4};
        vecs[3]  = '{1'b0, 32'h11, 3'd4, 32'h0,        32'hFFFFFF80, 1'b0, 4};
        vecs[4]  = '{1'b0, 32'h11, 3'd3, 32'h0,        32'h00000080, 1'b0, 4};
        vecs[5]  = '{1'b0, 32'h10, 3'd0, 32'h0,        32'hDEAD80EF, 1'b0, 4};
        vecs[6]  = '{1'b1, 32'h10, 3'd0, 32'h80011234, 32'h0,        1'b0, 4};
        vecs[7]  = '{1'b0, 32'h12, 3'd2, 32'h0,        32'hFFFF8001, 1'b0, 4};
        vecs[8]  = '{1'b0, 32'h12, 3'd0, 32'h0,        32'h0,        1'b1, 1};
        vecs[9]  = '{1'b0, 32'h10, 3'd0, 32'h0,        32'h80011234, 1'b0, 4};
        vecs[10] = '{1'b1, 32'h100, 3'd0, 32'hCAFEF00D, 32'h0,       1'b1, 1};
        vecs[11] = '{1'b1, 32'h10, 3'd7, 32'h55555555, 32'h0,        1'b1, 1};
        vecs[12] = '{1'b0, 32'h10, 3'd0, 32'h0,        32'h80011234, 1'b0, 4};
        vecs[13] = '{1'b0, 32'h12, 3'd1, 32'h0,        32'h00008001, 1'b0, 4};
        vecs[14] = '{1'b1, 32'h12, 3'd1, 32'hFFFFABCD, 32'h0,        1'b0, 4};
        vecs[15] = '{1'b0, 32'h10, 3'd0, 32'h0,        32'hABCD1234, 1'b0, 4};
        vecs[16] = '{1'b0, 32'h13, 3'd1, 32'h0,        32'h0,        1'b1, 1};
        vecs[17] = '{1'b1, 32'h13, 3'd3, 32'h12345677, 32'h0,        1'b0, 4};
        vecs[18] = '{1'b0, 32'h10, 3'd0, 32'h0,        32'h77CD1234, 1'b0, 4};
        vecs[19] = '{1'b0, 32'h13, 3'd4, 32'h0,        32'h00000077, 1'b0, 4};
        vecs[20] = '{1'b0, 32'h10, 3'd2, 32'h0,        32'h00001234, 1'b0, 4};

        b2.req = 1'b0; b2.we = 1'b0; b2.addr = 32'h0; b2.length = 3'd0; b2.wdata = 32'h0;
        b0.req = 1'b0; b0.we = 1'b0; b0.addr = 32'h0; b0.length = 3'd0; b0.wdata = 32'h0;

        // Reset state, with req asserted to show nothing is accepted under reset.
        b2.req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready", 32'(b2.ready), 32'h0);
        check("rst err", 32'(b2.err), 32'h0);
        check("rst rdata", b2.rdata, 32'h0);
        check("rst busy", 32'(b2.busy), 32'h0);
        check("rst busy0", 32'(b0.busy), 32'h0);
        b2.req = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 64; i++) run_checked("fill", 1'b1, 32'(i * 4), 3'd0, $urandom);

        for (int i = 0; i < 21; i++) begin
            model_access(vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].wdata, dr, de, dl);
            do_access(vecs[i].we, vecs[i].addr, vecs[i].len, vecs[i].wdata, r, e, lat);
            check($sformatf("vec%0d rdata", i), r, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Reset during WAIT of a word store: aborted, old contents survive.
        @(negedge clk);
        b2.req = 1'b1; b2.we = 1'b1; b2.addr = 32'h20; b2.length = 3'd0; b2.wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        b2.req = 1'b0;
        check("wait busy", 32'(b2.busy), 32'h1);
        rst = 1'b1;
        #1;
        check("abort ready", 32'(b2.ready), 32'h0);
        check("abort err", 32'(b2.err), 32'h0);
        check("abort rdata", b2.rdata, 32'h0);
        check("abort busy", 32'(b2.busy), 32'h0);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("abort no ready", 32'(b2.ready), 32'h0);
        end
        rst = 1'b0;
        run_checked("after abort", 1'b0, 32'h20, 3'd0, 32'h0);

        for (int i = 0; i < 200; i++) begin
            run_checked("random", 1'($urandom), $urandom_range(0, 32'h10F),
                        3'($urandom_range(0, 7)), $urandom);
        end

        // Continuous req with zero wait states: one acceptance every 3 cycles.
        @(negedge clk);
        b0.req = 1'b1; b0.we = 1'b0; b0.addr = 32'h0; b0.length = 3'd0;
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            check($sformatf("w0 ready c%0d", n), 32'(b0.ready), 32'((n % 3) == 2));
            check($sformatf("w0 busy c%0d", n), 32'(b0.busy), 32'((n % 3) != 0));
        end
        b0.req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit words of storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, legal range 0..15, meaning the wait states inserted before each legal access.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset: asynchronous, active-high.
REQ-005 SHALL have port req, input, 1 bit, meaning the CPU access request; sampled only while idle.
REQ-006 SHALL have port we, input, 1 bit, meaning 1 = store, 0 = load.
REQ-007 SHALL have port addr, input, 32 bits, meaning the byte address.
REQ-008 SHALL have port length, input, 3 bits, meaning the access size: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101..111 illegal.
REQ-009 SHALL have port wdata, input, 32 bits, meaning store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port rdata, output, 32 bits, meaning load data, extended to 32 bits; valid only while ready=1.
REQ-011 SHALL have port ready, output, 1 bit, meaning a one-cycle response pulse.
REQ-012 SHALL have port err, output, 1 bit, meaning the response is an error; valid only while ready=1.
REQ-013 SHALL have port busy, output, 1 bit, meaning state is not IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-015 SHALL, in IDLE with req=1, accept the request at that edge (E0) and latch we, addr, length and wdata; input changes after E0 SHALL have no effect.
REQ-016 SHALL classify an accepted request as an error when any of these hold: length is illegal; word access with addr[1:0]≠0; half access with addr[0]≠0; addr[31:2] ≥ DEPTH_WORDS.
REQ-017 SHALL handle an error request as follows: IDLE→RESP at E0, no memory change, ready=1 and err=1 in the cycle after E0, rdata=0.
REQ-018 SHALL handle a legal request as follows: IDLE→WAIT at E0; a 4-bit counter counts WAIT_CYCLES edges; WAIT→RESP at edge E0+WAIT_CYCLES+1; ready=1 and err=0 in the following cycle; with WAIT_CYCLES=0 the WAIT state lasts one cycle.
REQ-019 SHALL commit a store on the WAIT→RESP edge, modifying only the addressed lanes, little-endian: byte lane = addr[1:0]; half lanes = addr[1] ? [31:16] : [15:0]; word = all lanes.
REQ-020 SHALL capture load data into rdata on the WAIT→RESP edge: the selected lane(s) right-aligned, zero- or sign-extended per length.
REQ-021 SHALL drive rdata=0 on a store response.
REQ-022 SHALL always go RESP→IDLE on the next edge; ready therefore lasts exactly one cycle.
REQ-023 SHALL NOT accept a req in RESP; back-to-back requests SHALL be spaced at least one idle cycle apart (minimum period WAIT_CYCLES+3 cycles for legal accesses).
REQ-024 SHALL ignore req while busy=1, with no queuing.
REQ-025 SHALL register rdata, ready and err, with no combinational path from inputs to any output.

Reset
REQ-026 SHALL, while rst=1, immediately force state IDLE, counter 0, ready=0, err=0, rdata=0 and busy=0.
REQ-027 SHALL NOT reset memory contents.
REQ-028 SHALL, on rst during WAIT, abort the transaction with no store committed and no response generated; on rst during RESP, drop the pending response.
REQ-029 SHALL NOT accept a request while rst=1; the first acceptance is at the first rising edge after rst deasserts with req=1.

Verification
REQ-030 SHALL cover: word store 0xDEADBEEF to addr 0x10, then word load from 0x10 with WAIT_CYCLES=2 -> load ready exactly 4 cycles after acceptance, rdata=0xDEADBEEF, err=0.
REQ-031 SHALL cover: byte store 0x80 to addr 0x11, then signed byte load at 0x11 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load at 0x10 -> 0xDEAD80EF.
REQ-032 SHALL cover: signed half load at 0x12 after word 0x8001xxxx stored at 0x10 -> 0xFFFF8001; word load at 0x12 -> ready one cycle after acceptance, err=1, rdata=0, memory unchanged.
REQ-033 SHALL cover: store to addr 0x100 (word 64, DEPTH_WORDS=64) -> err=1; length=111 -> err=1; neither alters memory.
REQ-034 SHALL cover: rst asserted during WAIT of a word store 0x12345678 to 0x20 -> outputs 0 at once, no ready pulse; a later load from 0x20 returns the old contents.
REQ-035 SHALL cover: req held high continuously with WAIT_CYCLES=0 -> acceptance every 3 cycles, ready one cycle wide; req toggled while busy=1 -> ignored.
